dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have per requester X in {0 = CPU data port, 1 = loader/debug port}: mX_req  in  1  access request, held until ack.
REQ-004 SHALL have: mX_write  in  1  1 = store, 0 = load.
REQ-005 SHALL have: mX_address  in  12  byte address.
REQ-006 SHALL have: mX_wdata  in  32  store data.
REQ-007 SHALL have: mX_ack  out  1  one-cycle completion strobe.
REQ-008 SHALL have: mX_rdata  out  32  load data, valid only while mX_ack = 1 and mX_write was 0, else 0.
REQ-009 SHALL have memory-side ports DM_enable, DM_read, DM_write  out  1  strobes to the dm instance.
REQ-010 SHALL have: DM_address  out  12  byte address.
REQ-011 SHALL have: DM_in  out  32  store data.
REQ-012 SHALL have: DM_out  in  32  dm read data, valid the cycle after a read is issued.

Function
REQ-013 SHALL implement an FSM with states IDLE, ISSUE and RESP.
REQ-014 SHALL, in IDLE with any mX_req = 1, pick a winner per REQ-020, register its write, address and wdata, and go to ISSUE; otherwise stay in IDLE.
REQ-015 SHALL, in ISSUE, drive DM_enable = 1, DM_read = ~write, DM_write = write, DM_address and DM_in from the registered command, then go to RESP.
REQ-016 SHALL drive all DM_* outputs to 0 in IDLE and RESP.
REQ-017 SHALL, in RESP, assert mX_ack = 1 for the granted port only, and drive mX_rdata = DM_out if the access was a load.
REQ-018 SHALL give a fixed latency: a request sampled in IDLE at edge N is issued in cycle N+1 and acked in cycle N+2.
REQ-019 SHALL, in RESP, arbitrate ignoring the port being acked: if the other port requests, go directly to ISSUE (back-to-back, one access per 2 cycles); otherwise go to IDLE.
REQ-020 SHALL, on simultaneous requests, grant according to REQ-027 and REQ-028; a lone request is always granted.
REQ-021 SHALL never grant both ports in one cycle, and SHALL never assert m0_ack and m1_ack together.
REQ-022 SHALL ignore changes to mX_write, mX_address and mX_wdata after grant; the command registered in REQ-014 and REQ-019 is used.
REQ-023 SHALL pass addresses unmodified; word alignment (address/4) is the dm side's concern.
REQ-024 SHALL drop a request deasserted before its grant without side effects; a granted access always completes.

Reset
REQ-025 SHALL, with rst = 1 at a clock edge, set the state to IDLE, clear the command registers, set last_grant = 1, and force all outputs to 0.
REQ-026 SHALL abort an in-flight access if rst rises during ISSUE or RESP: no ack is given, and DM_* return to 0 in the next cycle.

Configuration
REQ-027 SHALL, with macro DM_ARBITER_RR_EN defined, use round-robin: on a tie, grant the port not equal to last_grant, and update last_grant on every grant.
REQ-028 SHALL, without DM_ARBITER_RR_EN, use fixed priority: on a tie m0 always wins, and last_grant is unused.

Verification
REQ-029 SHALL cover a single load: m0 load at address 8 with dm word 2 = 0x0000_0009 -> DM_read in cycle +1 with DM_address = 8, then m0_ack with m0_rdata = 9 in cycle +2.
REQ-030 SHALL cover store then load: m1 store 0xDEADBEEF to address 96, then m1 load from 96 -> m1_rdata = 0xDEADBEEF and exactly 2 DM_enable pulses.
REQ-031 SHALL cover a tie with DM_ARBITER_RR_EN after reset: m0 and m1 both held high for 4 accesses -> grant order m0, m1, m0, m1 with acks every 2 cycles.
REQ-032 SHALL cover a tie without the macro: both held high -> m0 is served continuously and m1_ack never asserts until m0_req drops.
REQ-033 SHALL cover reset mid-access: rst asserted during ISSUE of an m0 load -> no m0_ack, all outputs 0 the next cycle, state IDLE.
REQ-034 SHALL cover command hold: m0_address changes from 4 to 140 the cycle after grant -> DM_address = 4.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory (CPU data port m0, loader/debug port m1).
// Optional feature: define DM_ARBITER_RR_EN for round-robin tie-breaking; the default build uses fixed m0 priority.
module dm_arbiter (
  input  logic        clk,
  input  logic        rst,
  // requester 0: CPU data port
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [11:0] m0_address,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  // requester 1: loader/debug port
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [11:0] m1_address,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  // memory side
  output logic        DM_enable,
  output logic        DM_read,
  output logic        DM_write,
  output logic [11:0] DM_address,
  output logic [31:0] DM_in,
  input  logic [31:0] DM_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]  r_state;
  logic        r_port;
  logic        r_write;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
`ifdef DM_ARBITER_RR_EN
  logic        r_last_grant;
`endif

  logic w_in_idle, w_in_issue, w_in_resp;
  logic w_cand0, w_cand1, w_pick, w_gnt;

  assign w_in_idle  = (r_state == S_IDLE);
  assign w_in_issue = (r_state == S_ISSUE);
  assign w_in_resp  = (r_state == S_RESP);

  // The port being acked in RESP is excluded so the other port gets a back-to-back slot.
  always_comb begin
    w_cand0 = 1'b0;
    w_cand1 = 1'b0;
    w_pick  = 1'b0;
`ifdef DM_ARBITER_RR_EN
    w_cand0 = m0_req & ~(w_in_resp & ~r_port);
    w_cand1 = m1_req & ~(w_in_resp &  r_port);
    w_pick  = (w_cand0 & w_cand1) ? ~r_last_grant : w_cand1;
`else
    // m0 stays eligible in RESP: a CPU holding its request is served continuously.
    w_cand0 = m0_req;
    w_cand1 = m1_req & ~(w_in_resp & r_port);
    w_pick  = ~w_cand0;
`endif
  end

  assign w_gnt = (w_in_idle | w_in_resp) & (w_cand0 | w_cand1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_port  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef DM_ARBITER_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_gnt ? S_ISSUE : S_IDLE;
        S_ISSUE: r_state <= S_RESP;
        S_RESP:  r_state <= w_gnt ? S_ISSUE : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_gnt) begin
        r_port  <= w_pick;
        r_write <= w_pick ? m1_write   : m0_write;
        r_addr  <= w_pick ? m1_address : m0_address;
        r_wdata <= w_pick ? m1_wdata   : m0_wdata;
`ifdef DM_ARBITER_RR_EN
        r_last_grant <= w_pick;
`endif
      end
    end
  end

  assign DM_enable  = w_in_issue;
  assign DM_read    = w_in_issue & ~r_write;
  assign DM_write   = w_in_issue &  r_write;
  assign DM_address = w_in_issue ? r_addr  : '0;
  assign DM_in      = w_in_issue ? r_wdata : '0;

  // Reset during RESP suppresses the ack so an aborted access never completes.
  assign m0_ack   = w_in_resp & ~rst & ~r_port;
  assign m1_ack   = w_in_resp & ~rst &  r_port;
  assign m0_rdata = (m0_ack & ~r_write) ? DM_out : '0;
  assign m1_rdata = (m1_ack & ~r_write) ? DM_out : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter: transaction-level reference model plus directed literal checks.
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_write, m0_ack, m1_req, m1_write, m1_ack;
  logic [11:0] m0_address, m1_address, DM_address;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, DM_in;
  logic [31:0] DM_out = '0;
  logic        DM_enable, DM_read, DM_write;

  logic        q_req[2], q_wr[2];
  logic [11:0] q_ad[2];
  logic [31:0] q_wd[2];

  assign m0_req = q_req[0]; assign m0_write = q_wr[0]; assign m0_address = q_ad[0]; assign m0_wdata = q_wd[0];
  assign m1_req = q_req[1]; assign m1_write = q_wr[1]; assign m1_address = q_ad[1]; assign m1_wdata = q_wd[1];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_address(DM_address), .DM_in(DM_in), .DM_out(DM_out)
  );

  // memory the DUT talks to: word addressed, one-cycle read latency
  logic [31:0] mem[1024];
  always @(posedge clk) begin
    if (DM_write) mem[DM_address[11:2]] <= DM_in;
    if (DM_read)  DM_out <= mem[DM_address[11:2]];
  end

  // reference model: the access issued this cycle and the access acked this cycle
  logic [31:0] sm[1024];
  bit        iss_v, iss_p, iss_w, rsp_v, rsp_p, rsp_w, last;
  bit [11:0] iss_a;
  bit [31:0] iss_d, rsp_rd;
  bit        gr[2];
  int        n_chk = 0, n_fail = 0, n_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit was_iss, was_rsp, old_p, c0, c1, p;
    was_iss = iss_v; was_rsp = rsp_v; old_p = rsp_p;
    if (iss_v && iss_w) sm[iss_a[11:2]] = iss_d;
    if (rst) begin
      iss_v = 0; rsp_v = 0; last = 1; gr[0] = 0; gr[1] = 0;
      return;
    end
    rsp_v = iss_v; rsp_p = iss_p; rsp_w = iss_w;
    rsp_rd = iss_w ? 32'h0 : sm[iss_a[11:2]];
    if (rsp_v) gr[rsp_p] = 0;
    iss_v = 0;
    if (!was_iss) begin
      c0 = q_req[0]; c1 = q_req[1];
`ifdef DM_ARBITER_RR_EN
      if (was_rsp) begin if (old_p) c1 = 0; else c0 = 0; end
      p = (c0 && c1) ? !last : c1;
`else
      if (was_rsp && old_p) c1 = 0;
      p = !c0;
`endif
      if (c0 || c1) begin
        last = p; iss_v = 1; iss_p = p;
        iss_w = q_wr[p]; iss_a = q_ad[p]; iss_d = q_wd[p];
        gr[p] = 1;
      end
    end
  endfunction

  task automatic compare();
    bit e0, e1;
    e0 = rsp_v && !rst && !rsp_p;
    e1 = rsp_v && !rst &&  rsp_p;
    chk("DM_enable",  DM_enable,  iss_v);
    chk("DM_read",    DM_read,    iss_v && !iss_w);
    chk("DM_write",   DM_write,   iss_v && iss_w);
    chk("DM_address", DM_address, iss_v ? iss_a : 12'h0);
    chk("DM_in",      DM_in,      iss_v ? iss_d : 32'h0);
    chk("m0_ack",     m0_ack,     e0);
    chk("m1_ack",     m1_ack,     e1);
    chk("m0_rdata",   m0_rdata,   (e0 && !rsp_w) ? rsp_rd : 32'h0);
    chk("m1_rdata",   m1_rdata,   (e1 && !rsp_w) ? rsp_rd : 32'h0);
    if (DM_enable) n_en++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_ack(input int x, output logic [31:0] rd);
    bit got;
    got = 0; rd = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (rsp_v && rsp_p == x && !rst) begin
        got = 1;
        rd = x ? m1_rdata : m0_rdata;
      end
    end
    if (!got) chk("wait_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_req(input int x, input logic w, input logic [11:0] a, input logic [31:0] d);
    q_req[x] = 1; q_wr[x] = w; q_ad[x] = a; q_wd[x] = d;
  endtask

  task automatic drive_rand();
    bit acked;
    rst = ($urandom_range(0, 79) == 0);
    for (int x = 0; x < 2; x++) begin
      acked = rsp_v && rsp_p == x && !rst;
      if (rst) q_req[x] = 0;
      else if (q_req[x]) begin
        if (acked) begin
          if ($urandom_range(0, 1) == 0) set_req(x, 1'($urandom), 12'($urandom), $urandom);
          else q_req[x] = 0;
        end else if (gr[x]) begin
          if ($urandom_range(0, 3) == 0) begin q_wr[x] = 1'($urandom); q_ad[x] = 12'($urandom); q_wd[x] = $urandom; end
        end else if ($urandom_range(0, 7) == 0) q_req[x] = 0;
      end else if ($urandom_range(0, 2) == 0) set_req(x, 1'($urandom), 12'($urandom), $urandom);
    end
  endtask

  logic [31:0] rd;
  int          pat[8];

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; sm[i] = mem[i]; end
    for (int x = 0; x < 2; x++) begin q_req[x] = 0; q_wr[x] = 0; q_ad[x] = '0; q_wd[x] = '0; end
    rst = 1;
    @(negedge clk);
    tick(); tick();
    chk("reset_DM_enable", DM_enable, 0);
    chk("reset_acks", {m0_ack, m1_ack}, 0);
    rst = 0;
    tick();

    // single load of word 2
    mem[2] = 32'h9; sm[2] = 32'h9;
    set_req(0, 0, 12'd8, 32'h0);
    tick();
    chk("ld_issue_DM_read", DM_read, 1);
    chk("ld_issue_DM_address", DM_address, 12'd8);
    tick();
    chk("ld_m0_ack", m0_ack, 1);
    chk("ld_m0_rdata", m0_rdata, 32'h9);
    chk("model_ld_rdata", rsp_rd, 32'h9);
    q_req[0] = 0;
    tick();

    // command hold after grant
    set_req(0, 0, 12'd4, 32'h0);
    tick();
    q_ad[0] = 12'd140;
    #1 chk("hold_DM_address", DM_address, 12'd4);
    tick();
    q_req[0] = 0;
    tick();

    // store then load through m1
    n_en = 0;
    set_req(1, 1, 12'd96, 32'hDEADBEEF);
    wait_ack(1, rd);
    set_req(1, 0, 12'd96, 32'h0);
    wait_ack(1, rd);
    q_req[1] = 0;
    chk("st_ld_rdata", rd, 32'hDEADBEEF);
    chk("st_ld_enables", n_en, 2);
    chk("model_st_mem", sm[24], 32'hDEADBEEF);
    tick();

    // reset during ISSUE of a load
    set_req(0, 0, 12'd8, 32'h0);
    tick();
    chk("abort_issue_seen", DM_enable, 1);
    rst = 1;
    tick();
    chk("abort_no_ack", m0_ack, 0);
    chk("abort_rdata", m0_rdata, 0);
    rst = 0; q_req[0] = 0;
    tick();
    chk("abort_idle_DM_enable", DM_enable, 0);
    chk("abort_idle_acks", {m0_ack, m1_ack}, 0);

    // tie from reset: both held high for 8 cycles
    rst = 1; tick(); rst = 0;
    set_req(0, 0, 12'd0, 32'h0);
    set_req(1, 0, 12'd4, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = {30'd0, m1_ack, m0_ack};
    end
`ifdef DM_ARBITER_RR_EN
    for (int i = 0; i < 8; i++) chk($sformatf("rr_tie_%0d", i), pat[i], (i % 2 == 0) ? 0 : ((i % 4 == 1) ? 1 : 2));
`else
    for (int i = 0; i < 8; i++) chk($sformatf("fixed_tie_%0d", i), pat[i], (i % 2 == 0) ? 0 : 1);
`endif
    q_req[0] = 0;
    wait_ack(1, rd);
    chk("tie_m1_after_drop", rd, sm[1]);
    q_req[1] = 0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_rand();
      tick();
    end
    rst = 0; q_req[0] = 0; q_req[1] = 0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
